// File: rtl/ifft_8pt_stream.sv
// 8-point streaming inverse DFT. Loads N complex Q10.10 bins, then evaluates
// x[n] = (1/N) * sum_k X[k] e^{+j2*pi*n*k/N} with a single iterative complex MAC.
module ifft_8pt_stream #(
  parameter int W     = 21,
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int CW    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                out_valid,
  output logic                out_last,
  output logic                out_sat
);

  localparam int PW = W + CW;       // single product width
  localparam int SW = PW + 1;       // pr / pi sum width
  localparam int AW = 37;           // accumulator width
  localparam int SH = 10 + LOG2N;   // drop twiddle scale and divide by N
  localparam int CNTW = 2 * LOG2N;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);

  typedef enum logic {LOAD, COMPUTE} state_t;

  typedef struct packed {
    logic         sat;
    logic [W-1:0] val;
  } sat_t;

  state_t                 state;
  logic [LOG2N-1:0]       wr_ptr;
  logic [CNTW-1:0]        cnt;
  logic [LOG2N-1:0]       n, k, m;
  logic signed [W-1:0]    bin_re [N];
  logic signed [W-1:0]    bin_im [N];
  logic signed [W-1:0]    xr, xi;
  logic signed [CW-1:0]   cos_c, sin_c;
  logic signed [PW-1:0]   p_rc, p_is, p_rs, p_ic;
  logic signed [SW-1:0]   prod_re, prod_im;
  logic signed [AW-1:0]   acc_re, acc_im, nxt_re, nxt_im;
  sat_t                   res_re, res_im;

  // Floor-shift the accumulated sum back to Q10.10 and clamp to the W-bit range.
  function automatic sat_t sat_w(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    sat_t r;
    s = v >>> SH;
    r.sat = !((&s[AW-1:W-1]) || !(|s[AW-1:W-1]));
    if (!r.sat)       r.val = s[W-1:0];
    else if (s[AW-1]) r.val = {1'b1, {(W-1){1'b0}}};
    else              r.val = {1'b0, {(W-1){1'b1}}};
    return r;
  endfunction

  assign in_ready = (state == LOAD);

  // cnt walks c = 0..N*N-1; the upper half is n, the lower half is k.
  assign n = cnt[CNTW-1:LOG2N];
  assign k = cnt[LOG2N-1:0];
  assign m = n * k;   // wraps mod N by width

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cos_c = '0;
    sin_c = '0;
    case (m)
      3'd0: begin cos_c =  12'sd1024; sin_c =  12'sd0;    end
      3'd1: begin cos_c =  12'sd724;  sin_c =  12'sd724;  end
      3'd2: begin cos_c =  12'sd0;    sin_c =  12'sd1024; end
      3'd3: begin cos_c = -12'sd724;  sin_c =  12'sd724;  end
      3'd4: begin cos_c = -12'sd1024; sin_c =  12'sd0;    end
      3'd5: begin cos_c = -12'sd724;  sin_c = -12'sd724;  end
      3'd6: begin cos_c =  12'sd0;    sin_c = -12'sd1024; end
      3'd7: begin cos_c =  12'sd724;  sin_c = -12'sd724;  end
      default: begin cos_c = '0; sin_c = '0; end
    endcase
  end

  assign xr = bin_re[k];
  assign xi = bin_im[k];

  assign p_rc = PW'(xr) * PW'(cos_c);
  assign p_is = PW'(xi) * PW'(sin_c);
  assign p_rs = PW'(xr) * PW'(sin_c);
  assign p_ic = PW'(xi) * PW'(cos_c);

  assign prod_re = SW'(p_rc) - SW'(p_is);
  assign prod_im = SW'(p_rs) + SW'(p_ic);

  // k = 0 restarts the sum for a new output sample.
  assign nxt_re = (k == '0) ? AW'(prod_re) : acc_re + AW'(prod_re);
  assign nxt_im = (k == '0) ? AW'(prod_im) : acc_im + AW'(prod_im);

  assign res_re = sat_w(nxt_re);
  assign res_im = sat_w(nxt_im);

  // NOTE: the bin buffer carries no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      bin_re[wr_ptr] <= in_re;
      bin_im[wr_ptr] <= in_im;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      cnt       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + IDX_ONE;
            if (wr_ptr == IDX_LAST) begin
              state <= COMPUTE;
              cnt   <= '0;
            end
          end
        end
        COMPUTE: begin
          acc_re <= nxt_re;
          acc_im <= nxt_im;
          cnt    <= cnt + CNT_ONE;
          if (k == IDX_LAST) begin
            out_re    <= res_re.val;
            out_im    <= res_im.val;
            out_sat   <= res_re.sat | res_im.sat;
            out_valid <= 1'b1;
            if (n == IDX_LAST) begin
              out_last <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_8pt_stream.sv
// Directed bench for ifft_8pt_stream: hand-computed frames, timing, saturation,
// back-pressure during compute and reset in the middle of a frame.
module tb_ifft_8pt_stream;

  localparam int W = 21;
  localparam int A = 1048575;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] out_re, out_im;
  logic                out_valid, out_last, out_sat;

  always #5 clk = ~clk;

  ifft_8pt_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_sat  (out_sat)
  );

  int n_vec = 0;
  int n_err = 0;

  int x_re [8], x_im [8];
  int e_re [8], e_im [8], e_sat [8];
  bit e_chk [8];
  int g_re [8], g_im [8], g_last [8], g_sat [8], g_rdy [8], g_cyc [8];
  int g_n, lat, busy;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      x_re[i] = 0; x_im[i] = 0;
      e_re[i] = 0; e_im[i] = 0; e_sat[i] = 0; e_chk[i] = 1'b1;
    end
  endtask

  task automatic set_exp(input int i, input int re, input int im, input int sat);
    e_re[i] = re; e_im[i] = im; e_sat[i] = sat;
  endtask

  task automatic load_frame();
    for (int i = 0; i < 8; i++) begin
      in_re = W'(x_re[i]); in_im = W'(x_im[i]); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; in_re = '0; in_im = '0;
  endtask

  // Runs from compute cycle 0 up to and including the out_last cycle.
  task automatic collect_frame(input bit bp);
    int cyc = 0;
    g_n = 0; lat = -1;
    busy = (in_ready == 1'b0) ? 1 : 0;
    while (g_n < 8 && cyc < 200) begin
      if (bp) begin
        in_valid = 1'b1; in_re = W'($urandom); in_im = W'($urandom);
      end
      step();
      cyc++;
      if (!in_ready) busy++;
      if (out_valid) begin
        if (g_n == 0) lat = cyc + 1;
        g_re[g_n] = out_re; g_im[g_n] = out_im;
        g_last[g_n] = out_last; g_sat[g_n] = out_sat;
        g_rdy[g_n] = in_ready; g_cyc[g_n] = cyc;
        g_n++;
      end
    end
    in_valid = 1'b0; in_re = '0; in_im = '0;
  endtask

  task automatic verify_frame(input string tag);
    int stray = 0;
    check({tag, ".count"}, g_n, 8);
    check({tag, ".latency"}, lat, 9);
    check({tag, ".busy"}, busy, 64);
    for (int i = 0; i < g_n; i++) begin
      if (e_chk[i]) begin
        check($sformatf("%s.re[%0d]", tag, i), g_re[i], e_re[i]);
        check($sformatf("%s.im[%0d]", tag, i), g_im[i], e_im[i]);
        check($sformatf("%s.sat[%0d]", tag, i), g_sat[i], e_sat[i]);
      end
      check($sformatf("%s.last[%0d]", tag, i), g_last[i], (i == 7) ? 1 : 0);
      if (i > 0) check($sformatf("%s.gap[%0d]", tag, i), g_cyc[i] - g_cyc[i-1], 8);
    end
    if (g_n == 8) check({tag, ".ready_at_last"}, g_rdy[7], 1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) stray++;
    end
    check({tag, ".idle_pulses"}, stray, 0);
  endtask

  task automatic run_frame(input string tag, input bit bp);
    check({tag, ".ready_before"}, in_ready, 1);
    load_frame();
    collect_frame(bp);
    verify_frame(tag);
  endtask

  task automatic set_tone();
    clear_frame();
    x_re[1] = 8192;
    set_exp(0, 1024, 0, 0);     set_exp(1, 724, 724, 0);
    set_exp(2, 0, 1024, 0);     set_exp(3, -724, 724, 0);
    set_exp(4, -1024, 0, 0);    set_exp(5, -724, -724, 0);
    set_exp(6, 0, -1024, 0);    set_exp(7, 724, -724, 0);
  endtask

  task automatic set_dc();
    clear_frame();
    x_re[0] = 8192;
    for (int i = 0; i < 8; i++) set_exp(i, 1024, 0, 0);
  endtask

  task automatic set_sat(input int sgn);
    clear_frame();
    x_re[0] = sgn * A;  x_im[0] = 0;
    x_re[1] = sgn * A;  x_im[1] = -sgn * A;
    x_re[2] = 0;        x_im[2] = -sgn * A;
    x_re[3] = -sgn * A; x_im[3] = -sgn * A;
    x_re[4] = -sgn * A; x_im[4] = 0;
    x_re[5] = -sgn * A; x_im[5] = sgn * A;
    x_re[6] = 0;        x_im[6] = sgn * A;
    x_re[7] = sgn * A;  x_im[7] = sgn * A;
    for (int i = 2; i < 8; i++) e_chk[i] = 1'b0;
    set_exp(0, 0, 0, 0);
    set_exp(1, (sgn > 0) ? A : -A - 1, 0, 1);
  endtask

  initial begin
    int pulses;

    // Reset held with traffic on the input: nothing moves, outputs stay cleared.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; in_re = W'(i * 100 + 1); in_im = W'(i);
      step();
      check($sformatf("rst.valid[%0d]", i), out_valid, 0);
      check($sformatf("rst.ready[%0d]", i), in_ready, 1);
    end
    check("rst.out_re", out_re, 0);
    check("rst.out_im", out_im, 0);
    check("rst.out_last", out_last, 0);
    check("rst.out_sat", out_sat, 0);
    in_valid = 1'b0; in_re = '0; in_im = '0;
    rst = 1'b1;
    step();
    check("rst.release_ready", in_ready, 1);

    set_dc();
    run_frame("dc", 1'b0);

    set_tone();
    run_frame("tone", 1'b0);

    clear_frame();
    for (int i = 0; i < 8; i++) x_re[i] = 1024 * ((i % 4) + 1);
    set_exp(0, 2560, 0, 0);
    set_exp(2, -512, -512, 0);
    set_exp(4, -512, 0, 0);
    set_exp(6, -512, 512, 0);
    run_frame("periodic", 1'b0);

    set_dc();
    run_frame("backpressure", 1'b1);
    set_dc();
    run_frame("after_bp", 1'b0);

    // -1 LSB real, +1 LSB imag: the shift must floor toward minus infinity.
    clear_frame();
    x_re[0] = -1; x_im[0] = 1;
    for (int i = 0; i < 8; i++) set_exp(i, -1, 0, 0);
    run_frame("floor", 1'b0);

    set_sat(1);
    run_frame("sat_pos", 1'b0);
    set_sat(-1);
    run_frame("sat_neg", 1'b0);

    // Reset at compute cycle 20, after the n=0 and n=1 samples went out.
    set_tone();
    load_frame();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) pulses++;
    end
    check("midrst.pulses_before", pulses, 2);
    check("midrst.held_re", out_re, 724);
    rst = 1'b0;
    #1;
    check("midrst.out_re", out_re, 0);
    check("midrst.out_im", out_im, 0);
    check("midrst.ready", in_ready, 1);
    step();
    step();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (out_valid) pulses++;
    end
    check("midrst.pulses_after", pulses, 0);
    set_tone();
    run_frame("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
